// File: rtl/pixel_scheduler_if.sv
// Engine job/result bus and output pixel stream of the frame scheduler.
// The master side is the scheduler; the slave side is the engines plus
// the downstream colour-map/packer stage.
interface pixel_scheduler_if #(
    parameter int NUM_ENGINES = 4,
    parameter int ITER_W      = 8,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
);
    logic [NUM_ENGINES-1:0]        eng_start;
    logic [X_W-1:0]                eng_x;
    logic [Y_W-1:0]                eng_y;
    logic [NUM_ENGINES-1:0]        eng_done;
    logic [NUM_ENGINES*ITER_W-1:0] eng_iter;

    logic                          pix_valid;
    logic                          pix_ready;
    logic [ITER_W-1:0]             pix_iter;
    logic                          pix_sof;
    logic                          pix_eol;

    modport master (
        output eng_start, eng_x, eng_y,
        input  eng_done, eng_iter,
        output pix_valid, pix_iter, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  eng_start, eng_x, eng_y,
        output eng_done, eng_iter,
        input  pix_valid, pix_iter, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Frame scheduler: scans the frame in raster order, hands pixels round-robin
// to the iteration engines and re-serialises their results in raster order.
// Each engine owns one slot; dispatch and retire pointers walk the same
// round-robin sequence, so output order never depends on engine latency.
module pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int ITER_W      = 8,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    output logic               busy,
    output logic               frame_done,
    pixel_scheduler_if.master  bus
);

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int TOTAL = X_SIZE * Y_SIZE;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_DONE} slot_t;

    state_t            state;
    state_t            state_nxt;
    slot_t             slot_state [NUM_ENGINES];
    logic [ITER_W-1:0] slot_iter  [NUM_ENGINES];
    logic              slot_sof   [NUM_ENGINES];
    logic              slot_eol   [NUM_ENGINES];

    logic [PTR_W-1:0]  dp;
    logic [PTR_W-1:0]  rp;
    logic [X_W-1:0]    scan_x;
    logic [Y_W-1:0]    scan_y;
    logic [CNT_W-1:0]  retire_cnt;

    logic              scan_x_last;
    logic              scan_last;
    logic              dispatch_fire;
    logic              retire_fire;
    logic              retire_last;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENGINES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign scan_x_last   = (scan_x == X_W'(X_SIZE - 1));
    assign scan_last     = scan_x_last && (scan_y == Y_W'(Y_SIZE - 1));
    assign dispatch_fire = (state == ST_RUN) && (slot_state[dp] == SLOT_FREE);

    // Output side is derived purely from slot registers, never from pix_ready.
    assign bus.pix_valid = (slot_state[rp] == SLOT_DONE);
    assign bus.pix_iter  = bus.pix_valid ? slot_iter[rp] : '0;
    assign bus.pix_sof   = bus.pix_valid && slot_sof[rp];
    assign bus.pix_eol   = bus.pix_valid && slot_eol[rp];
    assign retire_fire   = bus.pix_valid && bus.pix_ready;
    assign retire_last   = retire_fire && (state == ST_DRAIN) &&
                           (retire_cnt == CNT_W'(TOTAL - 1));
    assign busy          = (state != ST_IDLE);

    // Controller state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Controller next state: start only matters in IDLE, the last dispatch ends RUN,
    // and the last retire handshake ends DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)                     state_nxt = ST_RUN;
            ST_RUN:   if (dispatch_fire && scan_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (retire_last)               state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    // Dispatch, completion capture, retire and frame accounting; a slot can only
    // see one of dispatch/completion/retire per cycle because each needs a
    // different slot state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bus.eng_start <= '0;
            bus.eng_x     <= '0;
            bus.eng_y     <= '0;
            frame_done    <= 1'b0;
            dp            <= '0;
            rp            <= '0;
            scan_x        <= '0;
            scan_y        <= '0;
            retire_cnt    <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_state[i] <= SLOT_FREE;
                slot_iter[i]  <= '0;
                slot_sof[i]   <= 1'b0;
                slot_eol[i]   <= 1'b0;
            end
        end else begin
            bus.eng_start <= '0;
            frame_done    <= retire_last;

            if (dispatch_fire) begin
                bus.eng_start <= NUM_ENGINES'(1) << dp;
                bus.eng_x     <= scan_x;
                bus.eng_y     <= scan_y;
                dp            <= next_ptr(dp);
                if (scan_x_last) begin
                    scan_x <= '0;
                    scan_y <= scan_last ? '0 : scan_y + 1'b1;
                end else begin
                    scan_x <= scan_x + 1'b1;
                end
            end

            if (retire_fire) begin
                rp         <= next_ptr(rp);
                retire_cnt <= retire_last ? '0 : retire_cnt + 1'b1;
            end

            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (dispatch_fire && dp == PTR_W'(i)) begin
                    slot_state[i] <= SLOT_BUSY;
                    slot_sof[i]   <= (scan_x == '0) && (scan_y == '0);
                    slot_eol[i]   <= scan_x_last;
                end else if (bus.eng_done[i] && slot_state[i] == SLOT_BUSY) begin
                    slot_state[i] <= SLOT_DONE;
                    slot_iter[i]  <= bus.eng_iter[i*ITER_W +: ITER_W];
                end else if (retire_fire && rp == PTR_W'(i)) begin
                    slot_state[i] <= SLOT_FREE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x2 frame with two engines.
// Engines are modelled with configurable latency; every output handshake and
// dispatch is compared against raster-order expectations kept by the bench.
module tb_pixel_scheduler;

    localparam int N     = 2;
    localparam int IW    = 8;
    localparam int XS    = 4;
    localparam int YS    = 2;
    localparam int XW    = 2;
    localparam int YW    = 1;
    localparam int TOTAL = XS * YS;

    logic aclk = 1'b0;
    logic aresetn;
    logic start;
    logic busy;
    logic frame_done;
    logic pix_ready;

    bit [N-1:0]  eng_done_m;
    bit [N-1:0]  spur_done;
    bit [IW-1:0] eng_res [N];
    bit          eng_pend [N];
    int          eng_cnt [N];
    int          lat_cfg [N];
    bit          lat_rand;
    bit          rand_ready;

    int errors = 0;
    int checks = 0;

    int hs_k, disp_k, fd_count;
    int ex, ey, dx, dy;
    bit stall_prev;
    logic [9:0] stall_word;

    pixel_scheduler_if #(.NUM_ENGINES(N), .ITER_W(IW), .X_W(XW), .Y_W(YW)) bus ();

    pixel_scheduler #(
        .NUM_ENGINES(N), .ITER_W(IW), .X_SIZE(XS), .Y_SIZE(YS), .X_W(XW), .Y_W(YW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    // Engine result depends only on the coordinate, so the bench knows every expected value.
    function automatic logic [IW-1:0] exp_iter(input int x, input int y);
        return IW'(x * 37 + y * 11 + 5);
    endfunction

    assign bus.eng_done  = eng_done_m | spur_done;
    assign bus.pix_ready = pix_ready;

    // Present each engine's held result on its slice of the shared result bus.
    always_comb begin
        bus.eng_iter = '0;
        for (int i = 0; i < N; i++) bus.eng_iter[i*IW +: IW] = eng_res[i];
    end

    // Engine model: latch job on eng_start, raise a one-cycle done after the latency.
    always @(posedge aclk) begin
        for (int i = 0; i < N; i++) begin
            eng_done_m[i] <= 1'b0;
            if (!aresetn) begin
                eng_pend[i] <= 1'b0;
            end else if (bus.eng_start[i]) begin
                eng_pend[i] <= 1'b1;
                eng_cnt[i]  <= lat_rand ? int'($urandom_range(20, 1)) : lat_cfg[i];
                eng_res[i]  <= exp_iter(int'(bus.eng_x), int'(bus.eng_y));
            end else if (eng_pend[i]) begin
                if (eng_cnt[i] <= 1) begin
                    eng_done_m[i] <= 1'b1;
                    eng_pend[i]   <= 1'b0;
                end else begin
                    eng_cnt[i] <= eng_cnt[i] - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor; inputs for the coming edge are already final when it runs.
    task automatic check_output();
        logic [N-1:0] exp_oh;
        if (!aresetn) begin
            hs_k = 0; disp_k = 0; ex = 0; ey = 0; dx = 0; dy = 0;
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            check("stall_valid", 32'(bus.pix_valid), 32'd1);
            check("stall_data", 32'({bus.pix_iter, bus.pix_sof, bus.pix_eol}), 32'(stall_word));
        end
        if (bus.eng_start != '0) begin
            exp_oh = '0;
            exp_oh[disp_k % N] = 1'b1;
            check("disp_engine", 32'(bus.eng_start), 32'(exp_oh));
            check("disp_xy", 32'({bus.eng_x, bus.eng_y}), 32'({XW'(dx), YW'(dy)}));
            check("disp_slot_free", 32'(disp_k - hs_k < N), 32'd1);
            disp_k++;
            if (dx == XS - 1) begin dx = 0; dy = (dy == YS - 1) ? 0 : dy + 1; end
            else dx++;
        end
        if (frame_done) begin
            check("fd_handshakes", 32'(hs_k), 32'(TOTAL));
            check("fd_dispatches", 32'(disp_k), 32'(TOTAL));
            check("fd_busy", 32'(busy), 32'd0);
            fd_count++;
            hs_k = 0; disp_k = 0;
        end
        if (bus.pix_valid && pix_ready) begin
            check("pix_out", 32'({bus.pix_iter, bus.pix_sof, bus.pix_eol}),
                  32'({exp_iter(ex, ey), (ex == 0 && ey == 0), (ex == XS - 1)}));
            hs_k++;
            if (ex == XS - 1) begin ex = 0; ey = (ey == YS - 1) ? 0 : ey + 1; end
            else ex++;
        end
        stall_prev = bus.pix_valid && !pix_ready;
        stall_word = {bus.pix_iter, bus.pix_sof, bus.pix_eol};
    endtask

    task automatic tick();
        if (rand_ready) pix_ready = 1'($urandom_range(1, 0));
        check_output();
        @(negedge aclk);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int f0;
        f0 = fd_count;
        for (int c = 0; c < budget && fd_count == f0; c++) tick();
        check("frame_done_seen", 32'(fd_count), 32'(f0 + 1));
        check("fd_single_pulse", 32'({frame_done, busy}), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        aresetn = 1'b0; start = 1'b0; pix_ready = 1'b1;
        lat_cfg[0] = 3; lat_cfg[1] = 3;
        @(negedge aclk);
        tick(); tick();

        // Reset state of every output.
        check("reset_outputs", 32'({busy, frame_done, bus.eng_start, bus.eng_x, bus.eng_y,
              bus.pix_valid, bus.pix_iter, bus.pix_sof, bus.pix_eol}), 32'd0);
        aresetn = 1'b1;
        tick();

        // Fixed latency 3 on both engines, no back-pressure.
        start_frame();
        check("t1_busy_no_disp", 32'({busy, bus.eng_start}), 32'b100);
        tick();
        check("t1_disp0", 32'({bus.eng_start, bus.eng_x, bus.eng_y}), 32'b01_00_0);
        tick();
        check("t1_disp1", 32'({bus.eng_start, bus.eng_x, bus.eng_y}), 32'b10_01_0);
        tick(); tick(); tick();
        check("t1_no_valid_yet", 32'(bus.pix_valid), 32'd0);
        tick();
        check("t1_first_pix", 32'({bus.pix_valid, bus.pix_iter, bus.pix_sof, bus.pix_eol}),
              32'({1'b1, 8'd5, 1'b1, 1'b0}));
        tick();
        check("t1_second_pix", 32'({bus.pix_valid, bus.pix_iter, bus.pix_sof, bus.pix_eol}),
              32'({1'b1, 8'd42, 1'b0, 1'b0}));
        tick();
        check("t1_redispatch", 32'({bus.eng_start, bus.eng_x, bus.eng_y}), 32'b01_10_0);
        wait_frame(200);

        // Engine 0 slow, engine 1 fast: engine 1 result must wait behind pixel (0,0).
        lat_cfg[0] = 10; lat_cfg[1] = 1;
        start_frame();
        for (int i = 0; i < 9; i++) tick();
        check("t2_hold_done", 32'({bus.pix_valid, bus.eng_start}), 32'd0);
        wait_frame(400);

        // Spurious done on free slots, then a start re-pulse mid-frame.
        lat_cfg[0] = 3; lat_cfg[1] = 3;
        spur_done = 2'b11;
        tick();
        spur_done = 2'b00;
        check("t4_spurious_ignored", 32'({bus.pix_valid, busy}), 32'd0);
        start_frame();
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frame(200);
        tick(); tick(); tick();
        check("t4_no_restart", 32'({busy, bus.eng_start}), 32'd0);

        // Reset mid-frame with results pending, then a clean restart.
        lat_cfg[0] = 5; lat_cfg[1] = 5;
        start_frame();
        for (int i = 0; i < 8; i++) tick();
        aresetn = 1'b0;
        tick();
        check("t5_reset_outputs", 32'({busy, frame_done, bus.eng_start, bus.eng_x, bus.eng_y,
              bus.pix_valid, bus.pix_iter, bus.pix_sof, bus.pix_eol}), 32'd0);
        aresetn = 1'b1;
        tick();
        lat_cfg[0] = 3; lat_cfg[1] = 3;
        start_frame();
        tick();
        check("t5_restart_disp", 32'({bus.eng_start, bus.eng_x, bus.eng_y}), 32'b01_00_0);
        wait_frame(200);

        // No ready: exactly N dispatches, then everything stalls.
        lat_cfg[0] = 2; lat_cfg[1] = 2;
        pix_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 20; i++) tick();
        check("t6_dispatch_count", 32'(disp_k), 32'(N));
        check("t6_stalled", 32'({busy, bus.eng_start, bus.pix_valid, bus.pix_iter, bus.pix_sof}),
              32'({1'b1, 2'b00, 1'b1, 8'd5, 1'b1}));
        pix_ready = 1'b1;
        wait_frame(200);

        // Random back-pressure and random engine latencies over several frames.
        lat_rand = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            start_frame();
            wait_frame(3000);
        end
        rand_ready = 1'b0;
        pix_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level scheduler for the fractal datapath.
- On a start pulse it scans the frame in raster order (x fastest) and dispatches pixel coordinates round-robin to NUM_ENGINES iteration engines, which have variable latency.
- It collects each engine's iteration count and re-serialises the results in strict raster order onto a valid/ready pixel stream, with sof/eol flags, for the colour-map/packer stage.

Parameters:
- NUM_ENGINES, 4, number of iteration engines; 2..8.
- ITER_W, 8, width of an iteration-count result.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- X_W, 10, coordinate width for x; must hold X_SIZE-1.
- Y_W, 9, coordinate width for y; must hold Y_SIZE-1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- start  in  1  one-cycle frame start request
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- eng_start  out  NUM_ENGINES  one-hot job launch, one cycle
- eng_x  out  X_W  job x coordinate; shared bus, valid with eng_start
- eng_y  out  Y_W  job y coordinate; shared bus, valid with eng_start
- eng_done  in  NUM_ENGINES  per-engine one-cycle result strobe
- eng_iter  in  NUM_ENGINES*ITER_W  per-engine result; slice i = bits [i*ITER_W +: ITER_W]
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream ready
- pix_iter  out  ITER_W  iteration count of the output pixel
- pix_sof  out  1  first pixel of frame (x=0, y=0)
- pix_eol  out  1  last pixel of line (x=X_SIZE-1)

Behaviour:
- Reset: aresetn low at a clock edge forces the following, regardless of what is in flight:
  - state IDLE, all slots FREE, dispatch and retire pointers 0, scan x=y=0;
  - busy=0, frame_done=0, eng_start=0, eng_x=0, eng_y=0, pix_valid=0, pix_iter=0, pix_sof=0, pix_eol=0.
  - Engines are expected to be reset by the same signal.
- Controller states:
  - IDLE: on start, go to RUN. busy=1 from the next cycle.
  - RUN: dispatching. After dispatching pixel (X_SIZE-1, Y_SIZE-1), go to DRAIN.
  - DRAIN: no dispatch. After the retire handshake of the last pixel, go to IDLE and pulse frame_done for one cycle; busy=0 in that same cycle.
  - start in RUN or DRAIN is ignored.
- Slot per engine i: state FREE/BUSY/DONE, plus a result register, sof flag and eol flag.
- Dispatch (RUN only, at most one per cycle):
  - Condition: slot[dp] is FREE.
  - Registered outputs for one cycle: eng_start[dp]=1, eng_x/eng_y = scan position.
  - Slot[dp] becomes BUSY and stores sof=(x==0&&y==0) and eol=(x==X_SIZE-1).
  - dp advances mod NUM_ENGINES; scan x increments, wraps to 0 with y+1 at X_SIZE-1.
  - If slot[dp] is not FREE, dispatch stalls and the pointer and scan hold.
- Timing: start sampled at edge 0 gives state RUN after edge 0, and first eng_start[0] with (0,0) after edge 1. With free slots, one pixel is dispatched per cycle.
- Completion:
  - eng_done[i] while slot[i] BUSY: capture eng_iter slice i; slot[i] becomes DONE at the next edge.
  - eng_done[i] on a FREE or DONE slot is ignored (no capture, no state change).
- Retire:
  - pix_valid = (slot[rp]==DONE), registered/derived with no combinational path from pix_ready.
  - pix_iter/pix_sof/pix_eol come from slot[rp] and are stable while pix_valid && !pix_ready.
  - On pix_valid && pix_ready: slot[rp] becomes FREE and rp advances mod NUM_ENGINES.
- Latency: eng_done at edge t gives pix_valid high after edge t if rp==i. A freed slot can be re-dispatched no earlier than the cycle after the handshake.
- Ordering: dispatch and retire pointers walk the same round-robin sequence, so output order is exactly raster order regardless of engine completion order. Results that complete early wait in DONE.
- Simultaneous events:
  - completion on slot j and retire of slot rp≠j in the same cycle are both honoured;
  - dispatch and retire in the same cycle are legal because they target different slots (FREE vs DONE).
- Frame accounting: a retire counter counts handshakes. The last pixel is handshake number X_SIZE*Y_SIZE. No pixel is lost or duplicated under arbitrary pix_ready back-pressure.

Test Plan:
1. X_SIZE=4, Y_SIZE=2, NUM_ENGINES=2, engines fixed latency 3, pix_ready=1, start pulse -> eng_start alternates 01,10 with coordinates (0,0),(1,0),(2,0),(3,0),(0,1)...; 8 pixels out in raster order; pix_sof only on the first; pix_eol on pixels 4 and 8; single frame_done pulse after the 8th handshake; busy then 0.
2. Same sizes, engine0 latency 10, engine1 latency 1 -> engine1 result held DONE; output order still (0,0) then (1,0); no eng_start to engine1 while its slot is not FREE.
3. Random pix_ready (50%), NUM_ENGINES=4, random latencies 1..20, 640x480 -> exactly 307200 handshakes, pix_iter equals a reference model in raster order, output stable during every stall.
4. start re-pulsed mid-frame and spurious eng_done on a FREE slot -> no effect on scan, pointers or output sequence.
5. aresetn low for one cycle mid-frame with results pending -> next cycle all outputs 0, state IDLE; a new start restarts at (0,0) with pix_sof on the first output.
6. pix_ready=0 throughout with 4 engines -> exactly 4 dispatches, then stall; eng_start stays 0 until pix_ready rises, after which one slot is freed per handshake.
